// File: rtl/cond_pkg.sv
// Shared definitions for the ARM condition unit: condition mnemonics and NZCV bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator: (cond, nzcv) -> pass.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register, condition gating of decoder enables,
// and saturating executed/squashed instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  input  logic             cnt_clr,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;
  logic             pass;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&val) ? val : val + one;
  endfunction

  cond_check u_check (
    .cond (cond),
    .nzcv (flags_q),
    .pass (pass)
  );

  assign cond_ex    = en & pass;
  assign pc_src     = pcs & cond_ex;
  assign reg_write  = reg_w & cond_ex & !no_write;
  assign mem_write  = mem_w & cond_ex;
  assign nzcv       = flags_q;
  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;

  // Flags only move for a passing instruction, so an instruction never sees its own update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q  <= 4'b0000;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      if (cond_ex) begin
        if (flag_w[1]) begin
          flags_q[FLAG_N] <= alu_flags[FLAG_N];
          flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
        end
        if (flag_w[0]) begin
          flags_q[FLAG_C] <= alu_flags[FLAG_C];
          flags_q[FLAG_V] <= alu_flags[FLAG_V];
        end
      end
      if (cnt_clr) begin
        exec_q   <= '0;
        squash_q <= '0;
      end else if (en) begin
        if (cond_ex) exec_q   <= sat_inc(exec_q);
        else         squash_q <= sat_inc(squash_q);
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed table, hand-written corner sequences, random run.
module tb_cond_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, pcs, reg_w, mem_w, no_write, cnt_clr;
  logic [3:0]    cond, alu_flags;
  logic [1:0]    flag_w;
  logic          pc_src, reg_write, mem_write, cond_ex;
  logic [3:0]    nzcv;
  logic [CW-1:0] exec_cnt, squash_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] m_nzcv;
  int         m_exec, m_squash;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .flag_w     (flag_w),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .no_write   (no_write),
    .cnt_clr    (cnt_clr),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .cond_ex    (cond_ex),
    .nzcv       (nzcv),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  // Reference: even codes name a base test, the odd code is its complement; 1110/1111 are always/never.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_in(input logic e, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic p, input logic rw,
                        input logic mw, input logic nw, input logic clr);
    en = e; cond = c; alu_flags = af; flag_w = fw;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw; cnt_clr = clr;
  endtask

  task automatic check_model(input string tag);
    logic cx;
    cx = en && ref_pass(cond, m_nzcv);
    chk({tag, ".cond_ex"},    {31'd0, cond_ex},   {31'd0, cx});
    chk({tag, ".pc_src"},     {31'd0, pc_src},    {31'd0, pcs && cx});
    chk({tag, ".reg_write"},  {31'd0, reg_write}, {31'd0, reg_w && cx && !no_write});
    chk({tag, ".mem_write"},  {31'd0, mem_write}, {31'd0, mem_w && cx});
    chk({tag, ".nzcv"},       {28'd0, nzcv},      {28'd0, m_nzcv});
    chk({tag, ".exec_cnt"},   32'(exec_cnt),      32'(m_exec));
    chk({tag, ".squash_cnt"}, 32'(squash_cnt),    32'(m_squash));
  endtask

  task automatic advance();
    logic cx;
    @(posedge clk);
    cx = en && ref_pass(cond, m_nzcv);
    if (cx && flag_w[1]) m_nzcv[3:2] = alu_flags[3:2];
    if (cx && flag_w[0]) m_nzcv[1:0] = alu_flags[1:0];
    if (cnt_clr) begin
      m_exec = 0; m_squash = 0;
    end else if (en) begin
      if (cx) m_exec   = (m_exec   + 1 > CMAX) ? CMAX : m_exec + 1;
      else    m_squash = (m_squash + 1 > CMAX) ? CMAX : m_squash + 1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, rw, mw, nw;
    logic       e_cex, e_pc, e_rw, e_mw;
    logic [3:0] e_nzcv;
  } vec_t;

  vec_t vt[12];

  initial begin
    // cond alu fw pcs rw mw nw | cex pc rw mw nzcv-before
    vt[0]  = '{4'h0, 4'h0, 2'b00, 0, 1, 0, 0,  0, 0, 0, 0, 4'b0000};
    vt[1]  = '{4'h1, 4'h0, 2'b00, 0, 1, 0, 0,  1, 0, 1, 0, 4'b0000};
    vt[2]  = '{4'hE, 4'h4, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000};
    vt[3]  = '{4'h0, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0100};
    vt[4]  = '{4'hE, 4'h8, 2'b11, 0, 1, 0, 1,  1, 0, 0, 0, 4'b0100};
    vt[5]  = '{4'hB, 4'h3, 2'b01, 0, 0, 1, 0,  1, 0, 0, 1, 4'b1000};
    vt[6]  = '{4'hA, 4'h0, 2'b00, 0, 1, 0, 0,  1, 0, 1, 0, 4'b1011};
    vt[7]  = '{4'hE, 4'h0, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1011};
    vt[8]  = '{4'h0, 4'hF, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000};
    vt[9]  = '{4'h0, 4'h0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000};
    vt[10] = '{4'hF, 4'h0, 2'b00, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000};
    vt[11] = '{4'hC, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0000};

    reset = 1'b0;
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    m_nzcv = 4'b0000; m_exec = 0; m_squash = 0;
    #12;
    chk("reset.nzcv",   {28'd0, nzcv}, 32'd0);
    chk("reset.exec",   32'(exec_cnt), 32'd0);
    chk("reset.squash", 32'(squash_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      set_in(1, vt[i].cond, vt[i].alu, vt[i].fw, vt[i].pcs, vt[i].rw, vt[i].mw, vt[i].nw, 0);
      #1;
      chk($sformatf("tbl%0d.cond_ex", i),   {31'd0, cond_ex},   {31'd0, vt[i].e_cex});
      chk($sformatf("tbl%0d.pc_src", i),    {31'd0, pc_src},    {31'd0, vt[i].e_pc});
      chk($sformatf("tbl%0d.reg_write", i), {31'd0, reg_write}, {31'd0, vt[i].e_rw});
      chk($sformatf("tbl%0d.mem_write", i), {31'd0, mem_write}, {31'd0, vt[i].e_mw});
      chk($sformatf("tbl%0d.nzcv", i),      {28'd0, nzcv},      {28'd0, vt[i].e_nzcv});
      check_model($sformatf("tbl%0d", i));
      advance();
    end
    chk("tbl.exec_after",   32'(exec_cnt),   32'd8);
    chk("tbl.squash_after", 32'(squash_cnt), 32'd4);

    // Stall: nothing moves even with a passing code and flag writes requested
    set_in(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    #1; check_model("stall");
    advance();
    chk("stall.nzcv_hold", {28'd0, nzcv}, 32'd0);

    // Saturation: 20 AL instructions
    for (int i = 0; i < 20; i++) begin
      set_in(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      #1; check_model($sformatf("sat%0d", i));
      advance();
    end
    chk("sat.exec", 32'(exec_cnt), 32'(CMAX));
    set_in(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    #1; check_model("clr");
    advance();
    chk("clr.exec",   32'(exec_cnt),   32'd0);
    chk("clr.squash", 32'(squash_cnt), 32'd0);

    // Mid-cycle asynchronous reset with flags 1111 and counters nonzero
    set_in(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
    #1; check_model("pre_rst_a"); advance();
    set_in(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    #1; check_model("pre_rst_b"); advance();
    chk("pre_rst.nzcv", {28'd0, nzcv}, 32'hF);
    set_in(0, 4'hF, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    #2; reset = 1'b0;
    #1;
    chk("arst.nzcv",   {28'd0, nzcv}, 32'd0);
    chk("arst.exec",   32'(exec_cnt), 32'd0);
    chk("arst.squash", 32'(squash_cnt), 32'd0);
    m_nzcv = 4'b0000; m_exec = 0; m_squash = 0;
    #1; reset = 1'b1;
    advance();
    set_in(1, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0);
    #1;
    chk("nv.mem_write", {31'd0, mem_write}, 32'd0);
    check_model("nv");
    advance();

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 31) == 0));
      #1; check_model($sformatf("rnd%0d", i));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
